button_clock_source: RTL

- Producer side of the Lab 4 display-advance path.
- Takes the raw board pushbutton and the 50 MHz board clock, and generates two signals for the downstream source-select mux:
  - a debounced button level with a one-cycle press pulse;
  - a slow free-running square wave.
- Both outputs are synchronous to clk, so the mux can select either without glitches.

---
 rtl/button_clock_source_if.sv | 24 ++
 rtl/button_clock_source.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/button_clock_source_if.sv
// Interface bundling the pushbutton input and the three outputs of
// button_clock_source. The slave modport is the design side; the master
// modport is whoever drives the button and observes the outputs.
`timescale 1ns/100ps
interface button_clock_source_if;
    logic button;   // raw, bouncy, asynchronous pushbutton
    logic clean;    // debounced level
    logic pulse;    // one-cycle press strobe
    logic clock;    // slow 50% square wave (data signal)

    modport slave (
        input  button,
        output clean,
        output pulse,
        output clock
    );

    modport master (
        output button,
        input  clean,
        input  pulse,
        input  clock
    );
endinterface

// File: rtl/button_clock_source.sv
// button_clock_source: debounces the board pushbutton into a clean level
// plus a one-cycle press pulse, and divides clk down into a slow square
// wave. All outputs are registered on clk so a downstream mux can switch
// between them without glitches.
// Optional build macro RELEASE_PULSE_EN: when defined, pulse also fires
// for one cycle when clean returns to 0.
`timescale 1ns/100ps
module button_clock_source #(
    parameter int unsigned STABLE_CNT = 500000,
    parameter int unsigned DIV_CNT    = 25000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    button_clock_source_if.slave   bus
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_WAIT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_WAIT_L = 2'd3
    } state_t;

    logic             s1_q, bs_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] divcnt_q, divcnt_d;
    logic             clock_q, clock_d;

    // Two-flop synchronizer; only bs_q is seen by the debounce logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            bs_q <= 1'b0;
        end else begin
            s1_q <= bus.button;
            bs_q <= s1_q;
        end
    end

    // Debounce next-state: a new level must persist STABLE_CNT cycles in a WAIT state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                clean_d = 1'b0;
                if (bs_q) begin
                    state_d = ST_WAIT_H;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_H: begin
                clean_d = 1'b0;
                if (!bs_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HIGH;
                    clean_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                clean_d = 1'b1;
                if (!bs_q) begin
                    state_d = ST_WAIT_L;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_L: begin
                clean_d = 1'b1;
                if (bs_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_LOW;
                    clean_d = 1'b0;
`ifdef RELEASE_PULSE_EN
                    pulse_d = 1'b1;
`else
                    pulse_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
    end

    // Debounce state, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    // Divider next-state: wrap at DIV_CNT-1 and flip the slow clock.
    always_comb begin
        divcnt_d = divcnt_q + CNT_ONE;
        clock_d  = clock_q;
        if (divcnt_q == DIV_LAST) begin
            divcnt_d = '0;
            clock_d  = ~clock_q;
        end
    end

    // Divider registers, independent of the debounce path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divcnt_q <= '0;
            clock_q  <= 1'b0;
        end else begin
            divcnt_q <= divcnt_d;
            clock_q  <= clock_d;
        end
    end

    assign bus.clean = clean_q;
    assign bus.pulse = pulse_q;
    assign bus.clock = clock_q;

endmodule
